// File: rtl/typedef_collection.sv
// Shared type definitions for the parameterised memory unit.
// Holds the request direction flag and the request FSM state encoding.
package typedef_collection;

  // Direction of a request presented on the request channel
  typedef enum logic {
    MEMORY_READ  = 1'b0,
    MEMORY_WRITE = 1'b1
  } MEMORY_FLAG_TYPE;

  // Request FSM: IDLE accepts requests, WAIT covers the extra read
  // latency cycles, RESP is the final cycle before the response strobe
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } fsm_state_t;

  // Number of index bits needed to address a storage array of the given depth
  function automatic int index_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/memory_array.sv
// Word storage for param_memory_unit: DEPTH words of DATA_WIDTH bits,
// byte-enabled write port and a registered (synchronous) read port.
// The storage itself is never reset; only the read register is.
// The read register returns zero on any cycle without a read enable so
// the parent can drive it straight onto a data bus that must idle at zero.
module memory_array #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [IDX_WIDTH-1:0]    wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [IDX_WIDTH-1:0]    rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Byte-masked write of the enabled lanes only
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Registered read; holds zero whenever no read is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_idx];
    end else begin
      rd_data_r <= '0;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/param_memory_unit.sv
// Parameterised single-port memory unit with a valid/ready request channel
// and a fixed-latency read response strobe.
// Writes complete in the accepting cycle and never leave IDLE; reads walk
// IDLE -> (WAIT) -> RESP and strobe resp_valid READ_LATENCY edges after
// acceptance, so read throughput is one per READ_LATENCY+1 cycles.
// Optional feature macro: MEMORY_UNIT_RANGE_CHECK_EN
//   defined   : address >= DEPTH is rejected and flagged on error
//   undefined : error stays 0 and the address is truncated to the index
//               width, so out-of-range addresses alias (DEPTH power of two)
module param_memory_unit
  import typedef_collection::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  MEMORY_FLAG_TYPE         rw_flag,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_memory_value,
  input  logic [DATA_WIDTH/8-1:0] byte_enable,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   read_memory_value,
  output logic                    error
);

  localparam int IDX_WIDTH = index_width(DEPTH);

  // Last value of the WAIT counter before moving on to RESP
  localparam logic [1:0] CNT_LAST = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  // First state after a read is accepted; WAIT is skipped for single-cycle latency
  localparam fsm_state_t READ_FIRST = (READ_LATENCY > 1) ? WAIT : RESP;

  fsm_state_t           state_r;
  logic [1:0]           cnt_r;
  logic [IDX_WIDTH-1:0] idx_r;
  logic                 in_range_r;
  logic                 req_ready_r;
  logic                 resp_valid_r;
  logic                 error_r;

  logic                 accept_s;
  logic                 in_range_s;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic [IDX_WIDTH-1:0] idx_s;

`ifdef MEMORY_UNIT_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  // Address is valid only below DEPTH; widened compare keeps DEPTH=2**ADDR_WIDTH legal
  always_comb begin
    in_range_s = ({1'b0, address} < DEPTH_EXT);
  end
`else
  logic unused_addr_s;

  // Every address maps somewhere; upper address bits are simply dropped
  always_comb begin
    in_range_s    = 1'b1;
    unused_addr_s = ^address;
  end
`endif

  // Request handshake and storage strobes
  always_comb begin
    idx_s    = address[IDX_WIDTH-1:0];
    accept_s = req_valid && req_ready_r;
    wr_en_s  = accept_s && (rw_flag == MEMORY_WRITE) && in_range_s;
    // The array read is issued on the edge that leaves RESP so the data
    // register and resp_valid rise together; out-of-range reads return zero
    rd_en_s  = (state_r == RESP) && in_range_r;
  end

  // Request FSM with latency counter and registered handshake/response outputs
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      idx_r        <= '0;
      in_range_r   <= 1'b1;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      resp_valid_r <= 1'b0;
      error_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (rw_flag == MEMORY_READ) begin
              idx_r       <= idx_s;
              in_range_r  <= in_range_s;
              cnt_r       <= 2'd0;
              req_ready_r <= 1'b0;
              state_r     <= READ_FIRST;
            end else begin
              // Writes stay in IDLE; a rejected write flags error for one cycle
              error_r <= !in_range_s;
            end
          end
        end
        WAIT: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        RESP: begin
          state_r      <= IDLE;
          cnt_r        <= 2'd0;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b1;
          error_r      <= !in_range_r;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 2'd0;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_memory_array (
    .clk     (CLOCK),
    .rst     (RESET),
    .wr_en   (wr_en_s),
    .wr_idx  (idx_s),
    .wr_data (write_memory_value),
    .wr_be   (byte_enable),
    .rd_en   (rd_en_s),
    .rd_idx  (idx_r),
    .rd_data (read_memory_value)
  );

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign error      = error_r;

endmodule

// File: tb/tb_param_memory_unit.sv
// Directed self-checking bench for param_memory_unit.
// Three instances share the data-side inputs but have private req_valid:
//   u0: READ_LATENCY=2, DEPTH=256 (main function, bytes, reset abort)
//   u1: READ_LATENCY=1, DEPTH=200 with range check / 128 without (config)
//   u2: READ_LATENCY=4, DEPTH=256 (long-latency back-to-back reads)
module tb_param_memory_unit;
  import typedef_collection::*;

`ifdef MEMORY_UNIT_RANGE_CHECK_EN
  localparam int B_DEPTH = 200;
`else
  localparam int B_DEPTH = 128;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid [3];
  MEMORY_FLAG_TYPE rw;
  logic [7:0]      addr;
  logic [15:0]     wdata;
  logic [1:0]      be;
  logic            ready  [3];
  logic            resp_v [3];
  logic [15:0]     rdata  [3];
  logic            err    [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_memory_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(2)) u0 (
    .CLOCK(clk), .RESET(rst), .req_valid(req_valid[0]), .req_ready(ready[0]),
    .rw_flag(rw), .address(addr), .write_memory_value(wdata), .byte_enable(be),
    .resp_valid(resp_v[0]), .read_memory_value(rdata[0]), .error(err[0]));

  param_memory_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(B_DEPTH), .READ_LATENCY(1)) u1 (
    .CLOCK(clk), .RESET(rst), .req_valid(req_valid[1]), .req_ready(ready[1]),
    .rw_flag(rw), .address(addr), .write_memory_value(wdata), .byte_enable(be),
    .resp_valid(resp_v[1]), .read_memory_value(rdata[1]), .error(err[1]));

  param_memory_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(4)) u2 (
    .CLOCK(clk), .RESET(rst), .req_valid(req_valid[2]), .req_ready(ready[2]),
    .rw_flag(rw), .address(addr), .write_memory_value(wdata), .byte_enable(be),
    .resp_valid(resp_v[2]), .read_memory_value(rdata[2]), .error(err[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    while (ready[idx] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL wait_ready u%0d: ready stuck at %b", idx, ready[idx]);
    end
  endtask

  task automatic do_write(input int idx, input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    wait_ready(idx);
    req_valid[idx] = 1'b1;
    rw = MEMORY_WRITE; addr = a; wdata = d; be = b;
    tick();
    req_valid[idx] = 1'b0;
    be = 2'b00; wdata = 16'h0000;
  endtask

  // Single read: checks latency in edges, data, error, and that the strobe is one cycle wide
  task automatic do_read(input int idx, input logic [7:0] a, input logic [15:0] exp,
                         input int lat, input logic exp_err, input string name);
    int n = 0;
    wait_ready(idx);
    req_valid[idx] = 1'b1;
    rw = MEMORY_READ; addr = a;
    tick();
    req_valid[idx] = 1'b0;
    addr = ~a; wdata = 16'hDEAD;
    while (resp_v[idx] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (n !== lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, n, lat); end
    total++;
    if (rdata[idx] !== exp) begin bad++; $display("FAIL %s data: got %h want %h", name, rdata[idx], exp); end
    total++;
    if (err[idx] !== exp_err) begin bad++; $display("FAIL %s error: got %b want %b", name, err[idx], exp_err); end
    tick();
    total++;
    if (resp_v[idx] !== 1'b0 || rdata[idx] !== 16'h0000 || err[idx] !== 1'b0) begin
      bad++;
      $display("FAIL %s after pulse: got v=%b d=%h e=%b want v=0 d=0000 e=0", name, resp_v[idx], rdata[idx], err[idx]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ready[i] !== 1'b1) begin bad++; $display("FAIL reset ready u%0d: got %b want 1", i, ready[i]); end
      total++;
      if (resp_v[i] !== 1'b0) begin bad++; $display("FAIL reset resp_valid u%0d: got %b want 0", i, resp_v[i]); end
      total++;
      if (rdata[i] !== 16'h0000) begin bad++; $display("FAIL reset rdata u%0d: got %h want 0000", i, rdata[i]); end
      total++;
      if (err[i] !== 1'b0) begin bad++; $display("FAIL reset error u%0d: got %b want 0", i, err[i]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    do_write(0, 8'h10, 16'hBEEF, 2'b11);
    do_read(0, 8'h10, 16'hBEEF, 2, 1'b0, "beef");
  endtask

  task automatic test_byte_enable();
    do_write(0, 8'h03, 16'h1234, 2'b11);
    do_write(0, 8'h03, 16'hAB00, 2'b10);
    do_read(0, 8'h03, 16'hAB34, 2, 1'b0, "be_hi");
    do_write(0, 8'h03, 16'hFFFF, 2'b00);
    do_read(0, 8'h03, 16'hAB34, 2, 1'b0, "be_none");
    do_write(0, 8'h03, 16'h77CD, 2'b01);
    do_read(0, 8'h03, 16'hABCD, 2, 1'b0, "be_lo");
  endtask

  task automatic test_back_to_back_writes();
    wait_ready(0);
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = 1'b1;
      rw = MEMORY_WRITE; be = 2'b11;
      addr = 8'h40 + 8'(i);
      wdata = 16'h1000 + 16'(i);
      total++;
      if (ready[0] !== 1'b1) begin bad++; $display("FAIL b2b_wr ready %0d: got %b want 1", i, ready[0]); end
      tick();
    end
    req_valid[0] = 1'b0;
    do_read(0, 8'h40, 16'h1000, 2, 1'b0, "b2b_wr0");
    do_read(0, 8'h43, 16'h1003, 2, 1'b0, "b2b_wr3");
  endtask

  // Three reads presented as early as the DUT allows; address is scrambled while busy
  task automatic test_back_to_back_reads(input int idx, input int lat);
    int acc = 0, pulses = 0, low = 0, cyc = 0;
    int acc_cyc [3];
    for (int k = 0; k < 3; k++) begin
      do_write(idx, 8'h20 + 8'(k), 16'hC0A0 + 16'(k) + 16'(lat * 16), 2'b11);
    end
    while ((acc < 3 || pulses < 3) && cyc < 60) begin
      if (ready[idx] === 1'b1 && acc < 3) begin
        req_valid[idx] = 1'b1;
        rw = MEMORY_READ;
        addr = 8'h20 + 8'(acc);
        acc_cyc[acc] = cyc;
        acc++;
      end else begin
        req_valid[idx] = 1'b0;
        rw = MEMORY_WRITE; addr = 8'hEE; wdata = 16'hDEAD; be = 2'b11;
      end
      tick();
      cyc++;
      if (ready[idx] !== 1'b1) low++;
      if (resp_v[idx] === 1'b1) begin
        if (pulses < 3) begin
          total++;
          if (rdata[idx] !== 16'hC0A0 + 16'(pulses) + 16'(lat * 16)) begin
            bad++;
            $display("FAIL b2b_rd L%0d data %0d: got %h want %h", lat, pulses, rdata[idx],
                     16'hC0A0 + 16'(pulses) + 16'(lat * 16));
          end
        end
        pulses++;
      end
    end
    req_valid[idx] = 1'b0;
    be = 2'b00;
    total++;
    if (pulses !== 3) begin bad++; $display("FAIL b2b_rd L%0d pulses: got %0d want 3", lat, pulses); end
    total++;
    if (low !== 3 * lat) begin bad++; $display("FAIL b2b_rd L%0d ready_low: got %0d want %0d", lat, low, 3 * lat); end
    total++;
    if (acc === 3 && (acc_cyc[1] - acc_cyc[0] !== lat + 1 || acc_cyc[2] - acc_cyc[1] !== lat + 1)) begin
      bad++;
      $display("FAIL b2b_rd L%0d spacing: got %0d,%0d want %0d", lat,
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], lat + 1);
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    do_write(0, 8'h05, 16'h7A5C, 2'b11);
    // Reset while in WAIT
    req_valid[0] = 1'b1; rw = MEMORY_READ; addr = 8'h05;
    tick();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (ready[0] !== 1'b1 || resp_v[0] !== 1'b0) begin
      bad++; $display("FAIL rst_wait state: got ready=%b v=%b want ready=1 v=0", ready[0], resp_v[0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_v[0] === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rst_wait pulses: got %0d want 0", seen); end
    // Reset while in RESP
    req_valid[0] = 1'b1; rw = MEMORY_READ; addr = 8'h05;
    tick();
    req_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    total++;
    if (resp_v[0] !== 1'b0 || rdata[0] !== 16'h0000 || ready[0] !== 1'b1) begin
      bad++; $display("FAIL rst_resp state: got v=%b d=%h ready=%b want v=0 d=0000 ready=1", resp_v[0], rdata[0], ready[0]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_v[0] === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rst_resp pulses: got %0d want 0", seen); end
    do_read(0, 8'h05, 16'h7A5C, 2, 1'b0, "rst_keep");
  endtask

`ifdef MEMORY_UNIT_RANGE_CHECK_EN
  task automatic test_config();
    do_write(1, 8'd250, 16'hFFFF, 2'b11);
    total++;
    if (err[1] !== 1'b1) begin bad++; $display("FAIL oor_wr error: got %b want 1", err[1]); end
    tick();
    total++;
    if (err[1] !== 1'b0) begin bad++; $display("FAIL oor_wr error_clear: got %b want 0", err[1]); end
    do_read(1, 8'd250, 16'h0000, 1, 1'b1, "oor_rd");
    do_write(1, 8'd199, 16'h1357, 2'b11);
    total++;
    if (err[1] !== 1'b0) begin bad++; $display("FAIL inr_wr error: got %b want 0", err[1]); end
    do_read(1, 8'd199, 16'h1357, 1, 1'b0, "inr_rd");
  endtask
`else
  task automatic test_config();
    do_write(1, 8'h85, 16'h5555, 2'b11);
    total++;
    if (err[1] !== 1'b0) begin bad++; $display("FAIL alias_wr error: got %b want 0", err[1]); end
    do_read(1, 8'h05, 16'h5555, 1, 1'b0, "alias_rd");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) req_valid[i] = 1'b0;
    rw = MEMORY_READ; addr = 8'h00; wdata = 16'h0000; be = 2'b00;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back_writes();
    test_back_to_back_reads(1, 1);
    test_back_to_back_reads(2, 4);
    test_back_to_back_reads(1, 1);
    test_reset_abort();
    test_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
